// File: rtl/rv64_pkg.sv
// rv64_pkg: RV64I opcodes, ID/EX register layout and opcode classification
package rv64_pkg;

    localparam int XLEN = 64;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            use_rs1;
        logic            use_rs2;
        logic            is_load;
        logic            illegal;
    } id_ex_t;

    function automatic logic use_rs2(input logic [6:0] op);
        return op inside {OPC_OP, OPC_OP_32, OPC_STORE, OPC_BRANCH};
    endfunction

    function automatic logic use_rs1(input logic [6:0] op);
        return use_rs2(op) || (op inside {OPC_OP_IMM, OPC_OP_IMM_32, OPC_LOAD, OPC_JALR});
    endfunction

    function automatic logic is_itype(input logic [6:0] op);
        return op inside {OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM_32, OPC_JALR, OPC_MISC_MEM, OPC_SYSTEM};
    endfunction

    function automatic logic is_legal(input logic [6:0] op);
        return use_rs1(op) || (op inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_MISC_MEM, OPC_SYSTEM});
    endfunction

endpackage

// File: rtl/id_stage_ctrl_imm_gen.sv
// imm_gen: sign-extended RV64I immediate; zero for R-type and unknown opcodes
module imm_gen
    import rv64_pkg::*;
(
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm
);

    logic [6:0] op;

    assign op  = instr[6:0];
    assign imm = is_itype(op)                       ? {{52{instr[31]}}, instr[31:20]} :
                 op == OPC_STORE                    ? {{52{instr[31]}}, instr[31:25], instr[11:7]} :
                 op == OPC_BRANCH                   ? {{52{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0} :
                 (op == OPC_LUI || op == OPC_AUIPC) ? {{32{instr[31]}}, instr[31:12], 12'b0} :
                 op == OPC_JAL                      ? {{44{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0} :
                 '0;

endmodule

// File: rtl/id_stage_ctrl.sv
// id_stage_ctrl: decode register plus ID/EX register with load-use stall, backpressure and flush
module id_stage_ctrl #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             if_valid,
    output logic             if_ready,
    input  logic [31:0]      if_instr,
    input  logic [XLEN-1:0]  if_pc,
    input  logic             flush,
    input  logic             ex_ready,
    output logic             id_valid,
    output logic [XLEN-1:0]  id_pc,
    output logic [31:0]      id_instr,
    output logic [XLEN-1:0]  id_imm,
    output logic [4:0]       id_rs1,
    output logic [4:0]       id_rs2,
    output logic [4:0]       id_rd,
    output logic             id_use_rs1,
    output logic             id_use_rs2,
    output logic             id_is_load,
    output logic             id_illegal,
    output logic [CNT_W-1:0] bubble_cnt
);

    import rv64_pkg::*;

    logic            d_valid, e_valid;
    logic [31:0]     d_instr;
    logic [XLEN-1:0] d_pc;
    logic [XLEN-1:0] d_imm;
    logic            d_use1, d_use2;
    logic            hazard, e_free, d_advance;
    id_ex_t          e, dec;

    imm_gen u_imm (.instr(d_instr), .imm(d_imm));

    assign d_use1 = use_rs1(d_instr[6:0]);
    assign d_use2 = use_rs2(d_instr[6:0]);
    assign dec = '{pc: d_pc, instr: d_instr, imm: d_imm,
                   rs1: d_instr[19:15], rs2: d_instr[24:20], rd: d_instr[11:7],
                   use_rs1: d_use1, use_rs2: d_use2,
                   is_load: d_instr[6:0] == OPC_LOAD, illegal: !is_legal(d_instr[6:0])};

    assign hazard = d_valid && e_valid && e.is_load && e.rd != 5'd0 &&
                    ((d_use1 && d_instr[19:15] == e.rd) || (d_use2 && d_instr[24:20] == e.rd));
    assign e_free    = !e_valid || ex_ready;
    assign d_advance = d_valid && !hazard && e_free;
    assign if_ready  = !flush && (!d_valid || d_advance);

    // D register: take a new instruction from IF, empty when it moves to E, drop on flush
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            d_valid <= 1'b0;
            d_instr <= '0;
            d_pc    <= '0;
        end else if (flush) begin
            d_valid <= 1'b0;
        end else if (if_valid && if_ready) begin
            d_valid <= 1'b1;
            d_instr <= if_instr;
            d_pc    <= if_pc;
        end else if (d_advance) begin
            d_valid <= 1'b0;
        end
    end

    // E register: load the decode of D, or drain to a bubble when EX takes it, else hold
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            e_valid <= 1'b0;
            e       <= '0;
        end else if (flush) begin
            e_valid <= 1'b0;
        end else if (d_advance) begin
            e_valid <= 1'b1;
            e       <= dec;
        end else if (ex_ready) begin
            e_valid <= 1'b0;
        end
    end

    // count bubbles that a load-use hazard pushes into EX
    always_ff @(posedge clk) begin
        if (!rst_n) bubble_cnt <= '0;
        else if (!flush && ex_ready && hazard) bubble_cnt <= bubble_cnt + 1'b1;
    end

    assign id_valid   = e_valid;
    assign id_pc      = e.pc;
    assign id_instr   = e.instr;
    assign id_imm     = e.imm;
    assign id_rs1     = e.rs1;
    assign id_rs2     = e.rs2;
    assign id_rd      = e.rd;
    assign id_use_rs1 = e.use_rs1;
    assign id_use_rs2 = e.use_rs2;
    assign id_is_load = e.is_load;
    assign id_illegal = e.illegal;

endmodule

// File: tb/tb_id_stage_ctrl.sv
// tb_id_stage_ctrl: directed and random checks of id_stage_ctrl against a behavioural model
module tb_id_stage_ctrl;

    logic        clk = 1'b0, rst_n = 1'b0, if_valid = 1'b0, flush = 1'b0, ex_ready = 1'b1;
    logic [31:0] if_instr = '0;
    logic [63:0] if_pc = '0;
    logic        if_ready, id_valid, id_use_rs1, id_use_rs2, id_is_load, id_illegal;
    logic [63:0] id_pc, id_imm;
    logic [31:0] id_instr, bubble_cnt;
    logic [4:0]  id_rs1, id_rs2, id_rd;

    id_stage_ctrl #(.XLEN(64), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_ready(if_ready),
        .if_instr(if_instr), .if_pc(if_pc), .flush(flush), .ex_ready(ex_ready),
        .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_is_load(id_is_load), .id_illegal(id_illegal), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    int n_pass = 0, n_tot = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // reference decode written straight from the RV64I opcode tables
    function automatic logic m_u1(input logic [31:0] i);
        case (i[6:0])
            7'h33, 7'h3B, 7'h13, 7'h1B, 7'h03, 7'h23, 7'h63, 7'h67: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic m_u2(input logic [31:0] i);
        case (i[6:0])
            7'h33, 7'h3B, 7'h23, 7'h63: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic m_legal(input logic [31:0] i);
        case (i[6:0])
            7'h37, 7'h17, 7'h6F, 7'h0F, 7'h73: return 1'b1;
            default: return m_u1(i);
        endcase
    endfunction

    function automatic logic [63:0] m_imm(input logic [31:0] i);
        logic signed [11:0] a;
        logic signed [12:0] b;
        logic signed [20:0] j;
        logic signed [31:0] u;
        longint r;
        r = 0;
        case (i[6:0])
            7'h03, 7'h13, 7'h1B, 7'h67, 7'h0F, 7'h73: begin a = i[31:20]; r = longint'(a); end
            7'h23: begin a = {i[31:25], i[11:7]}; r = longint'(a); end
            7'h63: begin b = {i[31], i[7], i[30:25], i[11:8], 1'b0}; r = longint'(b); end
            7'h37, 7'h17: begin u = {i[31:12], 12'h000}; r = longint'(u); end
            7'h6F: begin j = {i[31], i[19:12], i[20], i[30:21], 1'b0}; r = longint'(j); end
            default: r = 0;
        endcase
        return r;
    endfunction

    // model state: what sits in decode and what sits in the ID/EX slot
    logic        mdv = 1'b0, mev = 1'b0;
    logic [31:0] mdi = '0, mei = '0, mcnt = '0;
    logic [63:0] mdp = '0, mep = '0;
    logic        m_hz, m_adv, m_rdy;

    assign m_hz  = mdv && mev && mei[6:0] == 7'h03 && mei[11:7] != 5'd0 &&
                   ((m_u1(mdi) && mdi[19:15] == mei[11:7]) || (m_u2(mdi) && mdi[24:20] == mei[11:7]));
    assign m_adv = mdv && !m_hz && (!mev || ex_ready);
    assign m_rdy = !flush && (!mdv || m_adv);

    always @(posedge clk) begin
        if (!rst_n) begin
            mdv <= 1'b0; mev <= 1'b0; mcnt <= '0;
        end else if (flush) begin
            mdv <= 1'b0; mev <= 1'b0;
        end else begin
            if (m_adv) begin
                mev <= 1'b1; mei <= mdi; mep <= mdp;
            end else if (ex_ready) begin
                mev <= 1'b0;
                if (m_hz) mcnt <= mcnt + 1;
            end
            if (if_valid && m_rdy) begin
                mdv <= 1'b1; mdi <= if_instr; mdp <= if_pc;
            end else if (m_adv) begin
                mdv <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        #2;
        chk("if_ready", if_ready, m_rdy);
        chk("id_valid", id_valid, mev);
        chk("bubble_cnt", bubble_cnt, mcnt);
        if (mev) begin
            chk("id_pc", id_pc, mep);
            chk("id_instr", id_instr, mei);
            chk("id_imm", id_imm, m_imm(mei));
            chk("id_regs", {id_rs1, id_rs2, id_rd}, {mei[19:15], mei[24:20], mei[11:7]});
            chk("id_use", {id_use_rs1, id_use_rs2}, {m_u1(mei), m_u2(mei)});
            chk("id_is_load", id_is_load, mei[6:0] == 7'h03);
            chk("id_illegal", id_illegal, !m_legal(mei));
        end
    end

    task automatic drive(input logic v, input logic [31:0] ins, input logic [63:0] pc,
                         input logic fl, input logic er, input logic rn);
        @(negedge clk);
        if_valid = v; if_instr = ins; if_pc = pc; flush = fl; ex_ready = er; rst_n = rn;
        #3;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 64'h0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_valid"}, id_valid, 0);
        chk({nm, "_pc"}, id_pc, 0);
        chk({nm, "_imm"}, id_imm, 0);
        chk({nm, "_fields"}, {id_instr, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2, id_is_load, id_illegal}, 0);
        chk({nm, "_cnt"}, bubble_cnt, 0);
        chk({nm, "_if_ready"}, if_ready, 1);
    endtask

    localparam logic [31:0] ADDI = 32'hFFF00093, LD = 32'h00013283, ADD = 32'h00128333;
    localparam logic [31:0] LD0 = 32'h00013003, ADD0 = 32'h00100333, BAD = 32'h0000007F;

    logic [6:0]  ops [14] = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h1B, 7'h23, 7'h33,
                              7'h37, 7'h3B, 7'h63, 7'h67, 7'h6F, 7'h73, 7'h7F};
    logic [31:0] ri;

    initial begin
        drive(1'b0, 32'h0, 64'h0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 64'h0, 1'b0, 1'b1, 1'b0);
        idle();
        chk_zero("reset");

        // addi x1,x0,-1 issues two edges after acceptance
        drive(1'b1, ADDI, 64'h1000, 1'b0, 1'b1, 1'b1);
        idle();
        idle();
        chk("addi_valid", id_valid, 1);
        chk("addi_imm", id_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("addi_rd", id_rd, 1);
        chk("addi_use2", id_use_rs2, 0);
        chk("addi_pc", id_pc, 64'h1000);

        // ld x5 then add x6,x5,x1: one bubble
        drive(1'b1, LD, 64'h2000, 1'b0, 1'b1, 1'b1);
        drive(1'b1, ADD, 64'h2004, 1'b0, 1'b1, 1'b1);
        idle();
        chk("lu_ld", id_instr, LD);
        idle();
        chk("lu_bubble", id_valid, 0);
        chk("lu_cnt", bubble_cnt, 1);
        idle();
        chk("lu_add_valid", id_valid, 1);
        chk("lu_add", id_instr, ADD);

        // ld x0 never stalls
        drive(1'b1, LD0, 64'h3000, 1'b0, 1'b1, 1'b1);
        drive(1'b1, ADD0, 64'h3004, 1'b0, 1'b1, 1'b1);
        idle();
        chk("x0_ld", id_instr, LD0);
        idle();
        chk("x0_add_valid", id_valid, 1);
        chk("x0_add", id_instr, ADD0);
        chk("x0_cnt", bubble_cnt, 1);

        // illegal opcode still issues, with zero immediate
        drive(1'b1, BAD, 64'h4000, 1'b0, 1'b1, 1'b1);
        idle();
        idle();
        chk("ill_valid", id_valid, 1);
        chk("ill_flag", id_illegal, 1);
        chk("ill_imm", id_imm, 0);

        // backpressure: four addis, ex_ready low for three cycles
        drive(1'b1, 32'h00100093, 64'h5000, 1'b0, 1'b1, 1'b1);
        drive(1'b1, 32'h00200113, 64'h5004, 1'b0, 1'b1, 1'b1);
        drive(1'b1, 32'h00300193, 64'h5008, 1'b0, 1'b0, 1'b1);
        chk("bp_ready0", if_ready, 0);
        chk("bp_hold0", id_instr, 32'h00100093);
        drive(1'b1, 32'h00300193, 64'h5008, 1'b0, 1'b0, 1'b1);
        chk("bp_hold1", id_instr, 32'h00100093);
        drive(1'b1, 32'h00300193, 64'h5008, 1'b0, 1'b0, 1'b1);
        chk("bp_hold2", id_instr, 32'h00100093);
        chk("bp_ready2", if_ready, 0);
        drive(1'b1, 32'h00300193, 64'h5008, 1'b0, 1'b1, 1'b1);
        chk("bp_i1", id_instr, 32'h00100093);
        drive(1'b1, 32'h00400213, 64'h500C, 1'b0, 1'b1, 1'b1);
        chk("bp_i2", id_instr, 32'h00200113);
        idle();
        chk("bp_i3", id_instr, 32'h00300193);
        idle();
        chk("bp_i4", id_instr, 32'h00400213);
        chk("bp_i4_pc", id_pc, 64'h500C);
        idle();
        chk("bp_empty", id_valid, 0);

        // flush with both registers full
        drive(1'b1, 32'h00100093, 64'h6000, 1'b0, 1'b1, 1'b1);
        drive(1'b1, 32'h00200113, 64'h6004, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 32'h00300193, 64'h6008, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 32'h00300193, 64'h6008, 1'b1, 1'b0, 1'b1);
        chk("fl_ready", if_ready, 0);
        idle();
        chk("fl_valid", id_valid, 0);
        chk("fl_ready_after", if_ready, 1);
        idle();
        chk("fl_killed", id_valid, 0);
        chk("fl_cnt", bubble_cnt, 1);

        // reset mid-stream wins over flush and handshake
        drive(1'b1, LD, 64'h7000, 1'b0, 1'b0, 1'b1);
        drive(1'b1, ADD, 64'h7004, 1'b0, 1'b0, 1'b1);
        drive(1'b1, ADDI, 64'h7008, 1'b1, 1'b1, 1'b0);
        idle();
        chk_zero("midrst");

        // random traffic with a small register pool to provoke hazards
        for (int k = 0; k < 3000; k++) begin
            ri = $urandom;
            ri[6:0] = ops[$urandom_range(0, 13)];
            ri[11:7] = 5'($urandom_range(0, 3));
            ri[19:15] = 5'($urandom_range(0, 3));
            ri[24:20] = 5'($urandom_range(0, 3));
            drive($urandom_range(0, 3) != 0, ri, {$urandom, $urandom},
                  $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 199) != 0);
        end
        idle();
        idle();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/id_stage_ctrl.md
# id_stage_ctrl

Decode-stage controller for the 5-stage RV64I pipeline. It takes fetched instructions from IF over a valid/ready handshake and holds each one in a decode register. It decodes register fields, instruction class and the 64-bit immediate through `imm_gen`. Results go into the ID/EX pipeline register, with load-use stall insertion, backpressure from EX, and flush on redirect.

## Interface
Parameters:
- XLEN, 64, datapath/PC width
- CNT_W, 32, width of bubble performance counter

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- if_valid  in  1  IF presents an instruction
- if_ready  out  1  stage accepts this cycle
- if_instr  in  32  instruction word
- if_pc  in  XLEN  instruction PC
- flush  in  1  redirect from EX; kill everything in this stage
- ex_ready  in  1  EX accepts the ID/EX register this cycle
- id_valid  out  1  ID/EX register holds a real instruction
- id_pc  out  XLEN  PC of the issued instruction
- id_instr  out  32  raw instruction
- id_imm  out  XLEN  sign-extended immediate
- id_rs1, id_rs2, id_rd  out  5 each  register indices
- id_use_rs1, id_use_rs2  out  1 each  operand actually read
- id_is_load  out  1  opcode 0000011
- id_illegal  out  1  opcode not in RV64I set
- bubble_cnt  out  CNT_W  load-use bubbles inserted since reset

## Operation
- Two registers:
  - D (decode): d_valid, d_instr, d_pc.
  - E (ID/EX): all id_* outputs; id_valid is e_valid.
- Occupancy states, derived from {d_valid, e_valid}: EMPTY, D_ONLY, E_ONLY, BOTH.
- `e_free = ~e_valid | ex_ready`.
- Hazard, evaluated on D against E:
  - `hazard = d_valid & e_valid & id_is_load & id_rd!=0 & ((use_rs1(D) & rs1(D)==id_rd) | (use_rs2(D) & rs2(D)==id_rd))`.
- `d_advance = d_valid & ~hazard & e_free`.
- `if_ready = ~flush & (~d_valid | d_advance)`. This is combinational; there is no path from if_valid to if_ready.
- E update (non-flush cycle):
  - If d_advance: E loads the decode of D and e_valid=1.
  - Else if ex_ready: e_valid=0. When hazard is also set, this is an inserted bubble and bubble_cnt increments.
  - Else E holds.
- D update: if `if_valid & if_ready`, D loads if_instr/if_pc and d_valid=1. Else if d_advance, d_valid=0. Else D holds.
- Operand usage by opcode:
  - use_rs1: OP 0110011, OP-32 0111011, OP-IMM 0010011, OP-IMM-32 0011011, LOAD, STORE 0100011, BRANCH 1100011, JALR 1100111.
  - use_rs2: OP, OP-32, STORE, BRANCH.
- Legal opcodes: the use_rs1 list plus LUI 0110111, AUIPC 0010111, JAL 1101111, MISC-MEM 0001111, SYSTEM 1110011.
- Illegal opcode: id_illegal=1, id_imm=0, id_use_rs1=id_use_rs2=0. The instruction still issues with id_valid=1, and EX raises the trap.
- Data fields of E are don't-care when id_valid=0. They are still cleared at reset.

## Timing
- Reset (rst_n low at edge): d_valid=0, e_valid=0, every id_* field=0, bubble_cnt=0. if_ready=1 in the first cycle after reset. Reset overrides flush and handshakes.
- Latency: an instruction accepted at edge N appears on id_* after edge N+1, provided no hazard and E is free.
- Throughput: one instruction per cycle when ex_ready=1 and there are no hazards.
- Load-use: exactly one bubble per dependent pair. The dependent instruction issues one edge later than it would have without the hazard.
- Backpressure (ex_ready=0 with E full): id_* stays stable. D fills, then if_ready=0.
- Flush: at the edge, d_valid=0 and e_valid=0. if_ready=0 in the flush cycle. The count is unaffected. Flush has priority over ex_ready, hazard and if_valid.
- A load with rd=x0 never stalls.
- bubble_cnt wraps modulo 2^CNT_W.

## Structure
- Package `rv64_pkg`:
  - opcode localparams (OPC_LOAD, OPC_OP_IMM, …);
  - packed struct `id_ex_t`: pc, instr, imm, rs1, rs2, rd, use flags, is_load, illegal.
  - E is one register of type `id_ex_t`.
- Sub-module `imm_gen` is instantiated on d_instr. Its I-type coverage includes OP-IMM-32 (0011011).
- Opcode classification is a combinational function in the package, shared with the hazard logic.

## Test plan
- `addi x1,x0,-1` (0xFFF00093, pc 0x1000) with ex_ready=1 -> id_valid=1 after two edges; id_imm=0xFFFFFFFFFFFFFFFF, id_rd=1, id_use_rs2=0.
- `ld x5,0(x2)` (0x00013283) then `add x6,x5,x1` (0x00128333) back-to-back -> exactly one id_valid=0 cycle between them; bubble_cnt=1.
- `ld x0,0(x2)` (0x00013003) then `add x6,x0,x1` (0x00100333) -> no bubble; bubble_cnt stays 0.
- Stream of 4 instructions with ex_ready=0 for 3 cycles -> id_* constant throughout; if_ready=0 once D is full; no loss or duplication after release.
- flush asserted while D and E are both full -> next cycle id_valid=0 and if_ready=1; no killed instruction ever issues.
- 0x0000007F -> id_illegal=1, id_imm=0. rst_n low mid-stream -> all outputs and bubble_cnt are 0 after one edge.
